// File: rtl/md_pkg.sv
// Shared encodings and sizing helpers for the multiply/divide unit.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    function automatic int unsigned md_cnt_w(input int unsigned mult_cycles,
                                             input int unsigned div_cycles);
        int unsigned mx;
        mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(mx + 1);
    endfunction

    localparam int unsigned MD_CNT_W = md_cnt_w(MD_MULT_CYCLES_DEF, MD_DIV_CYCLES_DEF);

endpackage

// File: rtl/md_arith.sv
// Combinational product / quotient / remainder rules for MULT, MULTU, DIV, DIVU.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sdiv;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] uq;
    logic [31:0] ur;

    // Low 64 bits of sign-extended operands equal the signed 32x32 product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes so 0x80000000 / -1 never overflows.
    assign sdiv    = (op == MD_DIV);
    assign mag_a   = (sdiv && a[31]) ? (32'd0 - a) : a;
    assign mag_b   = (sdiv && b[31]) ? (32'd0 - b) : b;
    assign divisor = (b == '0) ? 32'd1 : mag_b;
    assign uq      = mag_a / divisor;
    assign ur      = mag_a % divisor;
    assign div0    = ((op == MD_DIV) || (op == MD_DIVU)) && (b == '0);

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                res_lo = (a[31] ^ b[31]) ? (32'd0 - uq) : uq;
                res_hi = a[31] ? (32'd0 - ur) : ur;
            end
            MD_DIVU: begin
                res_lo = uq;
                res_hi = ur;
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multi-cycle MIPS mult/div sequencer owning HI/LO.
// Define MD_UNIT_FLUSH_EN to let flush abort an in-flight op and discard a same-cycle start.
module md_unit_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CNT_W = md_cnt_w(MULT_CYCLES, DIV_CYCLES);

    md_state_e         state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [31:0]       res_hi;
    logic [31:0]       res_lo;
    logic              div0;
    logic              kill;

`ifdef MD_UNIT_FLUSH_EN
    assign kill = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign kill         = 1'b0;
`endif

    md_arith u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (div0)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start && !kill) begin
                        case (md_op)
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                op_q  <= md_op;
                                a_q   <= rs_val;
                                b_q   <= rt_val;
                                cnt   <= (md_op == MD_MULT || md_op == MD_MULTU)
                                         ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                                state <= MD_RUN;
                                busy  <= 1'b1;
                            end
                            MD_MTHI: hi <= rs_val;
                            MD_MTLO: lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                MD_RUN: begin
                    if (kill) begin
                        cnt   <= '0;
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_W'(1)) begin
                        if (!div0) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                        cnt   <= '0;
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
